// File: rtl/chacha20_stream_ctrl.sv
`default_nettype none
// ============================================================================
// chacha20_stream_ctrl : ChaCha20 job sequencer, keystream buffer and XOR path
// Rev 1.0
// ============================================================================
module chacha20_stream_ctrl #(
   parameter int LEN_W          = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [255:0]     job_key,
   input  logic [95:0]      job_nonce,
   input  logic [31:0]      job_counter,
   input  logic [LEN_W-1:0] job_len,
   input  logic             pt_valid,
   output logic             pt_ready,
   input  logic [31:0]      pt_data,
   output logic             ct_valid,
   input  logic             ct_ready,
   output logic [31:0]      ct_data,
   output logic             ct_last,
   output logic             job_done,
   output logic             job_err,
   output logic [1:0]       err_code,
   output logic             core_start,
   input  logic             core_busy,
   input  logic             core_done,
   output logic [255:0]     core_key,
   output logic [95:0]      core_nonce,
   output logic [31:0]      core_counter,
   output logic [511:0]     core_state,
   input  logic [511:0]     core_out
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_STREAM = 3'd3;
   localparam logic [2:0] S_FLUSH  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [1:0] c_err_ok  = 2'b00;
   localparam logic [1:0] c_err_tmo = 2'b01;
   localparam logic [1:0] c_err_ctr = 2'b10;

   logic [2:0]       r_state;
   logic [255:0]     r_key;
   logic [95:0]      r_nonce;
   logic [31:0]      r_counter;
   logic [LEN_W-1:0] r_rem;
   logic [3:0]       r_widx;
   logic [511:0]     r_ks;
   logic [TMO_W-1:0] r_tmo;
   logic [1:0]       r_err;
   logic             r_ct_valid;
   logic [31:0]      r_ct_data;
   logic             r_ct_last;

   logic w_job_fire;
   logic w_pt_fire;
   logic w_unused;

   // core_busy is informational only; the handshake relies on core_done alone
   assign w_unused   = core_busy;

   assign job_ready  = (r_state == S_IDLE);
   assign pt_ready   = (r_state == S_STREAM) && (!r_ct_valid || ct_ready);
   assign w_job_fire = job_valid && job_ready;
   assign w_pt_fire  = pt_valid && pt_ready;

   assign core_start   = (r_state == S_START);
   assign job_done     = (r_state == S_DONE);
   assign job_err      = (r_state == S_DONE) && (r_err != c_err_ok);
   assign err_code     = r_err;
   assign core_key     = r_key;
   assign core_nonce   = r_nonce;
   assign core_counter = r_counter;
   assign core_state   = '0;
   assign ct_valid     = r_ct_valid;
   assign ct_data      = r_ct_data;
   assign ct_last      = r_ct_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_key     <= '0;
         r_nonce   <= '0;
         r_counter <= '0;
         r_rem     <= '0;
         r_widx    <= '0;
         r_ks      <= '0;
         r_tmo     <= '0;
         r_err     <= c_err_ok;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_job_fire) begin
                  r_key     <= job_key;
                  r_nonce   <= job_nonce;
                  r_counter <= job_counter;
                  r_rem     <= job_len;
                  r_widx    <= '0;
                  r_tmo     <= '0;
                  r_err     <= c_err_ok;
                  r_state   <= (job_len == '0) ? S_DONE : S_START;
               end
            end
            S_START: begin
               r_tmo   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (core_done) begin
                  r_ks    <= core_out;
                  r_widx  <= '0;
                  r_state <= S_STREAM;
               end else if (r_tmo == c_tmo_last) begin
                  r_err   <= c_err_tmo;
                  r_state <= S_FLUSH;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            S_STREAM: begin
               if (w_pt_fire) begin
                  // keystream is consumed MSB word first, so shift rather than index
                  r_ks   <= {r_ks[479:0], 32'h0};
                  r_rem  <= r_rem - LEN_W'(1);
                  r_widx <= r_widx + 4'd1;
                  if (r_rem == LEN_W'(1)) begin
                     r_state <= S_FLUSH;
                  end else if (r_widx == 4'd15) begin
                     if (r_counter == 32'hFFFF_FFFF) begin
                        r_err   <= c_err_ctr;
                        r_state <= S_FLUSH;
                     end else begin
                        r_counter <= r_counter + 32'd1;
                        r_state   <= S_START;
                     end
                  end
               end
            end
            S_FLUSH: begin
               // leave as the pending word is accepted, so DONE sees ct_valid low
               if (!r_ct_valid || ct_ready) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ct_valid <= 1'b0;
         r_ct_data  <= '0;
         r_ct_last  <= 1'b0;
      end else if (w_pt_fire) begin
         r_ct_valid <= 1'b1;
         r_ct_data  <= pt_data ^ r_ks[511:480];
         r_ct_last  <= (r_rem == LEN_W'(1));
      end else if (ct_ready) begin
         r_ct_valid <= 1'b0;
         r_ct_last  <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_chacha20_stream_ctrl.sv
`default_nettype none
// ============================================================================
// tb_chacha20_stream_ctrl : vector table plus random jobs against a ChaCha20 model
// Rev 1.0
// ============================================================================
module tb_chacha20_stream_ctrl;

   localparam int LEN_W = 16;
   localparam int TMO   = 8;

   logic             clk;
   logic             rst_n;
   logic             job_valid;
   logic             job_ready;
   logic [255:0]     job_key;
   logic [95:0]      job_nonce;
   logic [31:0]      job_counter;
   logic [LEN_W-1:0] job_len;
   logic             pt_valid;
   logic             pt_ready;
   logic [31:0]      pt_data;
   logic             ct_valid;
   logic             ct_ready;
   logic [31:0]      ct_data;
   logic             ct_last;
   logic             job_done;
   logic             job_err;
   logic [1:0]       err_code;
   logic             core_start;
   logic             core_busy;
   logic             core_done;
   logic [255:0]     core_key;
   logic [95:0]      core_nonce;
   logic [31:0]      core_counter;
   logic [511:0]     core_state;
   logic [511:0]     core_out;

   chacha20_stream_ctrl #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid), .job_ready(job_ready), .job_key(job_key),
      .job_nonce(job_nonce), .job_counter(job_counter), .job_len(job_len),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
      .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data), .ct_last(ct_last),
      .job_done(job_done), .job_err(job_err), .err_code(err_code),
      .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
      .core_key(core_key), .core_nonce(core_nonce), .core_counter(core_counter),
      .core_state(core_state), .core_out(core_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- ChaCha20 block function (RFC 8439), byte 0 at MSB ----------------
   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic [511:0] chacha_block(input logic [255:0] k, input logic [95:0] n,
                                                 input logic [31:0] c);
      logic [31:0] s[16];
      logic [31:0] x[16];
      logic [511:0] r;
      int qa[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int qb[8] = '{4, 5, 6, 7, 5, 6, 7, 4};
      int qc[8] = '{8, 9, 10, 11, 10, 11, 8, 9};
      int qd[8] = '{12, 13, 14, 15, 15, 12, 13, 14};
      s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) s[4+i] = bswap(k[255-32*i -: 32]);
      s[12] = c;
      for (int i = 0; i < 3; i++) s[13+i] = bswap(n[95-32*i -: 32]);
      for (int i = 0; i < 16; i++) x[i] = s[i];
      for (int rd = 0; rd < 10; rd++) begin
         for (int j = 0; j < 8; j++) begin
            int a, b, cc, d;
            a = qa[j]; b = qb[j]; cc = qc[j]; d = qd[j];
            x[a] = x[a] + x[b];   x[d] = rotl(x[d] ^ x[a], 16);
            x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 12);
            x[a] = x[a] + x[b];   x[d] = rotl(x[d] ^ x[a], 8);
            x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 7);
         end
      end
      r = '0;
      for (int i = 0; i < 16; i++) r[511-32*i -: 32] = bswap(x[i] + s[i]);
      return r;
   endfunction

   // ---------------- core model ----------------
   int          dones = 0;
   logic [31:0] start_ctrs[$];
   int          start_cyc = 0;
   bit          core_dead = 0;

   initial begin
      int cd;
      logic [255:0] ck;
      logic [95:0]  cn;
      logic [31:0]  cc;
      core_done = 0; core_out = '0; core_busy = 0;
      cd = -1; ck = '0; cn = '0; cc = '0;
      forever begin
         @(negedge clk);
         core_done = 0;
         core_out  = {16{$urandom}};
         if (!rst_n) begin
            cd = -1;
            core_busy = 0;
         end else begin
            if (cd > 0) cd--;
            else if (cd == 0) begin
               chk("core_key_stable", {63'b0, (core_key !== ck) || (core_nonce !== cn)}, 64'd0);
               core_done = 1;
               core_busy = 0;
               core_out  = chacha_block(ck, cn, cc);
               dones++;
               cd = -1;
            end
            if (core_start) begin
               ck = core_key; cn = core_nonce; cc = core_counter;
               start_ctrs.push_back(core_counter);
               start_cyc = cyc_cnt;
               core_busy = 1;
               cd = core_dead ? -1 : int'($urandom_range(0, 4));
               chk("core_state_zero", {63'b0, |core_state}, 64'd0);
            end
         end
      end
   end

   // ---------------- job runner ----------------
   logic [255:0] cur_key;
   logic [95:0]  cur_nonce;
   logic [31:0]  last_w0 = 0;
   logic [31:0]  last_w1 = 0;
   bit           pat[4];

   task automatic run_job(input string tag, input logic [31:0] ctr0, input int len,
                          input int rmode, input bit zero_pt, input int exp_words,
                          input int exp_starts, input logic [1:0] exp_err);
      logic [31:0] pt[$];
      logic [31:0] got_d[$];
      bit          got_l[$];
      int          pidx, viol, hs_cyc, done_cyc, acc_cyc, k, bound;
      bit          done_seen;
      logic        d_err;
      logic [1:0]  d_code;
      logic [511:0] blk;
      logic [31:0] kw;
      pidx = 0; viol = 0; hs_cyc = 0; done_cyc = -100; acc_cyc = -100; k = 0; bound = 0;
      done_seen = 0; d_err = 0; d_code = 0;
      for (int i = 0; i < len; i++) pt.push_back(zero_pt ? 32'h0 : $urandom);
      start_ctrs.delete();
      dones = 0;

      @(negedge clk);
      job_valid = 1; job_key = cur_key; job_nonce = cur_nonce;
      job_counter = ctr0; job_len = LEN_W'(len);
      pt_valid = 0; ct_ready = 1;
      #1;
      while (!job_ready && bound < 50) begin
         @(negedge clk); #1; bound++;
      end
      hs_cyc = cyc_cnt;
      chk({tag, " handshake"}, {63'b0, job_ready}, 64'd1);

      for (int c = 0; c < 3000 && !done_seen; c++) begin
         @(negedge clk);
         job_valid = 0;
         pt_valid  = (pidx < len) && ($urandom_range(0, 3) != 0);
         pt_data   = (pidx < len) ? pt[pidx] : $urandom;
         case (rmode)
            0:       ct_ready = 1;
            1:       ct_ready = (k < 4) ? pat[k] : 1'($urandom_range(0, 1));
            default: ct_ready = 1'($urandom_range(0, 1));
         endcase
         k++;
         #1;
         if (job_done) begin
            done_seen = 1; done_cyc = cyc_cnt; d_err = job_err; d_code = err_code;
         end
         if (pt_ready && ct_valid && !ct_ready) viol++;
         if (pt_ready && pidx >= 16 * dones) viol++;
         if (pt_valid && pt_ready) pidx++;
         if (ct_valid && ct_ready) begin
            got_d.push_back(ct_data); got_l.push_back(ct_last); acc_cyc = cyc_cnt;
         end
      end

      chk({tag, " done_seen"}, {63'b0, done_seen}, 64'd1);
      chk({tag, " job_err"}, {63'b0, d_err}, {63'b0, exp_err != 2'b00});
      chk({tag, " err_code"}, {62'b0, d_code}, {62'b0, exp_err});
      chk({tag, " words_out"}, got_d.size(), exp_words);
      chk({tag, " pt_accepted"}, pidx, exp_words);
      chk({tag, " core_starts"}, start_ctrs.size(), exp_starts);
      for (int i = 0; i < start_ctrs.size(); i++)
         chk({tag, " start_ctr"}, start_ctrs[i], ctr0 + 32'(i));
      for (int i = 0; i < got_d.size() && i < len; i++) begin
         blk = chacha_block(cur_key, cur_nonce, ctr0 + 32'(i / 16));
         kw  = blk[511-32*(i%16) -: 32];
         chk($sformatf("%s ct_word%0d", tag, i), got_d[i], pt[i] ^ kw);
         chk($sformatf("%s ct_last%0d", tag, i), {63'b0, got_l[i]}, {63'b0, i == len - 1});
      end
      chk({tag, " ready_rule_violations"}, viol, 0);
      if (exp_words > 0) chk({tag, " done_after_last_accept"}, done_cyc - acc_cyc, 1);
      else if (exp_err == 2'b01) chk({tag, " timeout_latency"}, done_cyc - start_cyc, 10);
      else chk({tag, " len0_latency"}, done_cyc - hs_cyc, 1);
      if (got_d.size() >= 2) begin
         last_w0 = got_d[0];
         last_w1 = got_d[1];
      end

      @(negedge clk);
      pt_valid = 0;
      #1;
      chk({tag, " done_one_cycle"}, {63'b0, job_done}, 64'd0);
      chk({tag, " ready_after"}, {63'b0, job_ready}, 64'd1);
      chk({tag, " err_code_held"}, {62'b0, err_code}, {62'b0, exp_err});
   endtask

   typedef struct {
      logic [31:0] ctr;
      int          len;
      int          rmode;
      bit          zpt;
      bit          dead;
      int          words;
      int          starts;
      logic [1:0]  err;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int acc, dp;
      logic [31:0] rc;
      int rl, rw, rs;
      logic [1:0] re;
      longint avail, maxw;

      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      cur_key   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      cur_nonce = 96'h000000090000004a00000000;

      //          ctr            len rmode zpt dead words starts err
      tbl[0] = '{32'd1,          16, 0, 1'b1, 1'b0, 16, 1, 2'b00};
      tbl[1] = '{32'd1,          20, 0, 1'b1, 1'b0, 20, 2, 2'b00};
      tbl[2] = '{32'd1,          16, 1, 1'b0, 1'b0, 16, 1, 2'b00};
      tbl[3] = '{32'hFFFF_FFFF,  17, 2, 1'b0, 1'b0, 16, 1, 2'b10};
      tbl[4] = '{32'd5,           4, 0, 1'b0, 1'b1,  0, 1, 2'b01};
      tbl[5] = '{32'd9,           5, 2, 1'b0, 1'b0,  5, 1, 2'b00};
      tbl[6] = '{32'd3,           0, 0, 1'b0, 1'b0,  0, 0, 2'b00};
      tbl[7] = '{32'hFFFF_FFFE,  40, 2, 1'b0, 1'b0, 32, 2, 2'b10};
      tbl[8] = '{32'd7,          33, 2, 1'b0, 1'b0, 33, 3, 2'b00};

      rst_n = 0; job_valid = 0; job_key = '0; job_nonce = '0; job_counter = '0; job_len = '0;
      pt_valid = 0; pt_data = '0; ct_ready = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset job_ready", {63'b0, job_ready}, 64'd1);
      chk("reset ct_valid", {63'b0, ct_valid}, 64'd0);
      chk("reset pt_ready", {63'b0, pt_ready}, 64'd0);
      chk("reset job_done", {63'b0, job_done}, 64'd0);
      chk("reset core_start", {63'b0, core_start}, 64'd0);
      chk("reset err_code", {62'b0, err_code}, 64'd0);
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 9; i++) begin
         core_dead = tbl[i].dead;
         run_job($sformatf("vec%0d", i), tbl[i].ctr, tbl[i].len, tbl[i].rmode, tbl[i].zpt,
                 tbl[i].words, tbl[i].starts, tbl[i].err);
         core_dead = 0;
         if (i == 0) begin
            chk("rfc_ct_w0", last_w0, 32'h10f1e7e4);
            chk("rfc_ct_w1", last_w1, 32'hd13b5915);
         end
      end

      // random jobs judged by counter-space arithmetic
      for (int j = 0; j < 8; j++) begin
         cur_key   = {8{$urandom}};
         cur_nonce = {3{$urandom}};
         rc = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
         rl = int'($urandom_range(0, 50));
         avail = 64'h1_0000_0000 - {32'h0, rc};
         maxw  = avail * 16;
         rw = (longint'(rl) < maxw) ? rl : int'(maxw);
         re = (longint'(rl) > maxw) ? 2'b10 : 2'b00;
         rs = (rw + 15) / 16;
         run_job($sformatf("rnd%0d", j), rc, rl, 2, 1'b0, rw, rs, re);
      end

      // reset in the middle of a streaming job
      cur_key   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      cur_nonce = 96'h000000090000004a00000000;
      @(negedge clk);
      job_valid = 1; job_key = cur_key; job_nonce = cur_nonce; job_counter = 32'd1; job_len = 16'd32;
      acc = 0;
      for (int c = 0; c < 200 && acc < 5; c++) begin
         @(negedge clk);
         job_valid = 0; pt_valid = 1; pt_data = $urandom; ct_ready = 1;
         #1;
         if (ct_valid && ct_ready) acc++;
      end
      chk("rst_mid reached_stream", {63'b0, acc >= 5}, 64'd1);
      @(negedge clk);
      rst_n = 0;
      #1;
      chk("rst_mid ct_valid", {63'b0, ct_valid}, 64'd0);
      chk("rst_mid ct_data", {32'b0, ct_data}, 64'd0);
      chk("rst_mid pt_ready", {63'b0, pt_ready}, 64'd0);
      chk("rst_mid core_key", {63'b0, |core_key}, 64'd0);
      chk("rst_mid core_counter", {32'b0, core_counter}, 64'd0);
      chk("rst_mid job_done", {63'b0, job_done}, 64'd0);
      pt_valid = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      dp = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         if (job_done) dp++;
      end
      chk("rst_mid no_done_pulse", dp, 0);
      chk("rst_mid job_ready_after", {63'b0, job_ready}, 64'd1);

      run_job("post_reset", 32'd1, 16, 0, 1'b1, 16, 1, 2'b00);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
